tick_period_meter: RTL and testbench

TICK_PERIOD_METER -- requirements
Module: tick_period_meter

---
 rtl/tick_meter_pkg.sv | 13 +
 rtl/edge_detect_rise.sv | 20 ++
 rtl/tick_period_meter.sv | 115 +++++++++++
 tb/tb_tick_period_meter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/tick_meter_pkg.sv
// Shared types and constants for the tick period meter.
package tick_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } state_t;

    // Consecutive identical periods needed before locked asserts.
    localparam int LOCK_N_DEFAULT = 4;

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector for a clk-synchronous input. The history register
// resets high so an input already high at reset release is not an edge.
module edge_detect_rise (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Previous sample of d.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) d_q <= 1'b1;
        else       d_q <= d;
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures the cycle distance between rising edges of tick_in, flags a
// timeout when no edge arrives within 2^W-1 cycles, and reports locked
// once LOCK_N consecutive identical periods have been seen.
module tick_period_meter
    import tick_meter_pkg::*;
#(
    parameter int W      = 16,
    parameter int LOCK_N = LOCK_N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         tick_in,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         timeout,
    output logic         locked
);

    // Counter value on the last no-edge cycle before timing out.
    localparam logic [W-1:0] CNT_LIM   = {{(W-1){1'b1}}, 1'b0};
    localparam logic [W-1:0] CNT_ONE   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [3:0]   MATCH_MAX = 4'd15;
    localparam logic [3:0]   LOCK_THR  = 4'(LOCK_N);

    state_t       state, state_n;
    logic [W-1:0] cnt, cnt_n, cnt_inc, period_n;
    logic [3:0]   match, match_n;
    logic         pv_n, to_n, lk_n;
    logic         rise;
    logic         at_limit;

    edge_detect_rise u_edge (
        .clk   (clk),
        .reset (reset),
        .d     (tick_in),
        .rise  (rise)
    );

    // cnt never exceeds 2^W-2 while measuring, so cnt+1 always fits in W bits.
    assign cnt_inc  = cnt + CNT_ONE;
    assign at_limit = (cnt == CNT_LIM);

    // Register segment: state, counter, match count and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            locked       <= 1'b0;
            match        <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            period       <= period_n;
            period_valid <= pv_n;
            timeout      <= to_n;
            locked       <= lk_n;
            match        <= match_n;
        end
    end

    // Next-state logic; en low overrides everything.
    always_comb begin
        state_n = state;
        if (!en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:    state_n = ARMED;
                ARMED:   if (rise) state_n = MEASURE;
                MEASURE: if (!rise && at_limit) state_n = ARMED;
                default: state_n = IDLE;
            endcase
        end
    end

    // Datapath/output next values. A zero match count means "no previous
    // period to compare against", so the first period after arming, en-off
    // or timeout always starts a fresh run of 1.
    always_comb begin
        cnt_n    = '0;
        period_n = period;
        pv_n     = 1'b0;
        to_n     = timeout;
        lk_n     = locked;
        match_n  = match;
        if (!en) begin
            to_n    = 1'b0;
            lk_n    = 1'b0;
            match_n = '0;
        end else if (state == MEASURE) begin
            if (rise) begin
                // An edge on the timeout cycle wins and reports 2^W-1.
                period_n = cnt_inc;
                pv_n     = 1'b1;
                to_n     = 1'b0;
                if (match != '0 && cnt_inc == period)
                    match_n = (match == MATCH_MAX) ? match : match + 4'd1;
                else
                    match_n = 4'd1;
                lk_n = (match_n >= LOCK_THR);
            end else if (at_limit) begin
                to_n    = 1'b1;
                lk_n    = 1'b0;
                match_n = '0;
            end else begin
                cnt_n = cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: a W=16 and a W=4 instance share one stimulus
// stream and are compared every cycle against a timestamp-based model.
module tb_tick_period_meter;

    localparam int LOCK_N = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        tick_in;
    logic [15:0] per16;
    logic [3:0]  per4;
    logic        pv16, pv4, to16, to4, lk16, lk4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tick_period_meter #(.W(16), .LOCK_N(LOCK_N)) u16 (
        .clk(clk), .reset(reset), .en(en), .tick_in(tick_in),
        .period(per16), .period_valid(pv16), .timeout(to16), .locked(lk16)
    );

    tick_period_meter #(.W(4), .LOCK_N(LOCK_N)) u4 (
        .clk(clk), .reset(reset), .en(en), .tick_in(tick_in),
        .period(per4), .period_valid(pv4), .timeout(to4), .locked(lk4)
    );

    // Reference model: mode 0 idle, 1 waiting for first edge, 2 measuring
    // from the timestamp of the last edge. Index 0 -> W=16, 1 -> W=4.
    int now;
    bit m_prev;
    int m_mode [2];
    int m_t0   [2];
    int m_per  [2];
    bit m_pv   [2];
    bit m_to   [2];
    bit m_lk   [2];
    int m_nh   [2];
    int m_hist [2][LOCK_N];

    task automatic model_reset();
        m_prev = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0; m_t0[k] = 0; m_per[k] = 0;
            m_pv[k] = 0; m_to[k] = 0; m_lk[k] = 0; m_nh[k] = 0;
        end
    endtask

    task automatic model_step(input bit t, input bit e);
        bit ev;
        int el, lim;
        bit same;
        ev = t && !m_prev;
        m_prev = t;
        now++;
        for (int k = 0; k < 2; k++) begin
            lim = (k == 0) ? (1 << 16) - 1 : (1 << 4) - 1;
            m_pv[k] = 1'b0;
            if (!e) begin
                m_mode[k] = 0; m_to[k] = 0; m_lk[k] = 0; m_nh[k] = 0;
            end else if (m_mode[k] == 0) begin
                m_mode[k] = 1;
            end else if (m_mode[k] == 1) begin
                if (ev) begin m_mode[k] = 2; m_t0[k] = now; end
            end else begin
                el = now - m_t0[k];
                if (ev) begin
                    m_per[k] = el; m_pv[k] = 1; m_to[k] = 0; m_t0[k] = now;
                    for (int i = 0; i < LOCK_N - 1; i++) m_hist[k][i] = m_hist[k][i+1];
                    m_hist[k][LOCK_N-1] = el;
                    if (m_nh[k] < LOCK_N) m_nh[k]++;
                    same = 1'b1;
                    for (int i = 0; i < LOCK_N; i++) if (m_hist[k][i] != el) same = 1'b0;
                    m_lk[k] = (m_nh[k] == LOCK_N) && same;
                end else if (el >= lim) begin
                    m_to[k] = 1; m_lk[k] = 0; m_nh[k] = 0; m_mode[k] = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("u16.period",       32'(per16), m_per[0]);
        chk("u16.period_valid", 32'(pv16),  32'(m_pv[0]));
        chk("u16.timeout",      32'(to16),  32'(m_to[0]));
        chk("u16.locked",       32'(lk16),  32'(m_lk[0]));
        chk("u4.period",        32'(per4),  m_per[1]);
        chk("u4.period_valid",  32'(pv4),   32'(m_pv[1]));
        chk("u4.timeout",       32'(to4),   32'(m_to[1]));
        chk("u4.locked",        32'(lk4),   32'(m_lk[1]));
    endtask

    task automatic cyc(input bit t, input bit e);
        tick_in = t;
        en      = e;
        @(posedge clk);
        model_step(t, e);
        #1;
        check_all();
    endtask

    // One rising edge, then the input stays low so the next pulse is g later.
    task automatic pulse(input int g, input int w = 1);
        repeat (w) cyc(1'b1, 1'b1);
        repeat (g - w) cyc(1'b0, 1'b1);
    endtask

    task automatic do_reset();
        tick_in = 1'b0;
        reset   = 1'b1;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        int g, lastg, w;
        now = 0;
        reset = 1'b1; tick_in = 1'b1; en = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        // Input high through reset release: the first real edge only arms.
        cyc(1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b1);

        // mod-10 max_tick stream.
        repeat (7) pulse(10);

        // 10,10,10,7 after a fresh arm through en.
        repeat (2) cyc(1'b0, 1'b0);
        repeat (4) pulse(10);
        pulse(7);
        pulse(5);

        // Single tick then silence: W=4 times out, W=16 keeps counting.
        cyc(1'b1, 1'b1);
        repeat (19) cyc(1'b0, 1'b1);
        repeat (3) pulse(5);

        // Edge exactly 2^4-1 cycles after the previous one.
        pulse(15);
        pulse(15);
        pulse(4, 2);

        // en dropped mid-count, then re-enabled.
        pulse(10);
        repeat (3) cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        repeat (2) cyc(1'b0, 1'b1);
        pulse(6);
        pulse(6);
        pulse(3);

        // Reset in the middle of a measurement.
        pulse(8);
        repeat (3) cyc(1'b0, 1'b1);
        do_reset();
        repeat (2) cyc(1'b0, 1'b1);
        pulse(9);
        pulse(9);
        pulse(4);

        // Randomised gaps with frequent repeats so locking happens.
        lastg = 8;
        repeat (80) begin
            if ($urandom_range(0, 19) == 0)
                repeat ($urandom_range(1, 3)) cyc(1'(($urandom_range(0, 1))), 1'b0);
            g = ($urandom_range(0, 9) < 7) ? lastg : int'($urandom_range(2, 20));
            w = int'($urandom_range(1, g - 1));
            pulse(g, w);
            lastg = g;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
